fuzzy_input_serializer: RTL and testbench

FUZZY_INPUT_SERIALIZER -- requirements
Module: fuzzy_input_serializer

---
 rtl/fuzzy_input_serializer_if.sv | 25 ++
 rtl/fuzzy_input_serializer.sv | 90 +++++++++
 tb/tb_fuzzy_input_serializer.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/fuzzy_input_serializer_if.sv
// rtl/fuzzy_input_serializer_if.sv - frame handshake and digit-serial output bundle
interface fuzzy_input_serializer_if #(
  parameter int BIT_WIDTH = 8,
  parameter int N_INPUTS  = 8
);
  logic                          io_inValid;
  logic                          io_inReady;
  logic [N_INPUTS*BIT_WIDTH-1:0] io_inData1;
  logic [N_INPUTS*BIT_WIDTH-1:0] io_inData2;
  logic                          io_start;
  logic [N_INPUTS-1:0]           io_bits1;
  logic [N_INPUTS-1:0]           io_bits2;
  logic                          io_busy;
  logic                          io_frameDone;

  modport master (
    output io_inValid, io_inData1, io_inData2,
    input  io_inReady, io_start, io_bits1, io_bits2, io_busy, io_frameDone
  );

  modport slave (
    input  io_inValid, io_inData1, io_inData2,
    output io_inReady, io_start, io_bits1, io_bits2, io_busy, io_frameDone
  );
endinterface

// File: rtl/fuzzy_input_serializer.sv
// rtl/fuzzy_input_serializer.sv - parallel operand frames to MSB-first digit streams
module fuzzy_input_serializer #(
  parameter int BIT_WIDTH = 8,
  parameter int N_INPUTS  = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  fuzzy_input_serializer_if.slave  bus
);
  localparam int CW = $clog2(BIT_WIDTH);
  localparam int W  = N_INPUTS * BIT_WIDTH;
  localparam logic [CW-1:0] LAST = CW'(BIT_WIDTH - 1);

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_sh1;
  logic [W-1:0]  r_sh2;
  logic [W-1:0]  w_sh1_nxt;
  logic [W-1:0]  w_sh2_nxt;
  logic          w_last;
  logic          w_ready;
  logic          w_xfer;

  assign w_last  = (r_state == S_SHIFT) && (r_cnt == LAST);
  assign w_ready = (r_state == S_IDLE) || w_last;
  assign w_xfer  = bus.io_inValid && w_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_xfer) w_state_nxt = S_SHIFT;
      S_SHIFT: if (w_last && !w_xfer) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Each word shifts left on its own so its MSB always holds the current digit.
  always_comb begin
    w_sh1_nxt = '0;
    w_sh2_nxt = '0;
    for (int k = 0; k < N_INPUTS; k++) begin
      w_sh1_nxt[k*BIT_WIDTH +: BIT_WIDTH] = {r_sh1[k*BIT_WIDTH +: BIT_WIDTH-1], 1'b0};
      w_sh2_nxt[k*BIT_WIDTH +: BIT_WIDTH] = {r_sh2[k*BIT_WIDTH +: BIT_WIDTH-1], 1'b0};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt <= '0;
      r_sh1 <= '0;
      r_sh2 <= '0;
    end else if (w_xfer) begin
      r_cnt <= '0;
      r_sh1 <= bus.io_inData1;
      r_sh2 <= bus.io_inData2;
    end else if (w_last) begin
      r_cnt <= '0;
      r_sh1 <= '0;
      r_sh2 <= '0;
    end else if (r_state == S_SHIFT) begin
      r_cnt <= r_cnt + CW'(1);
      r_sh1 <= w_sh1_nxt;
      r_sh2 <= w_sh2_nxt;
    end
  end

  always_comb begin
    bus.io_inReady   = w_ready;
    bus.io_start     = (r_state == S_SHIFT);
    bus.io_busy      = (r_state == S_SHIFT);
    bus.io_frameDone = w_last;
    bus.io_bits1     = '0;
    bus.io_bits2     = '0;
    for (int k = 0; k < N_INPUTS; k++) begin
      bus.io_bits1[k] = r_sh1[k*BIT_WIDTH + BIT_WIDTH - 1];
      bus.io_bits2[k] = r_sh2[k*BIT_WIDTH + BIT_WIDTH - 1];
    end
  end
endmodule

// File: tb/tb_fuzzy_input_serializer.sv
// tb/tb_fuzzy_input_serializer.sv - randomized bench with frame-level reference model
module tb_fuzzy_input_serializer;
  logic clk;
  logic reset;

  fuzzy_input_serializer_if #(.BIT_WIDTH(8), .N_INPUTS(8)) u_if ();
  fuzzy_input_serializer_if #(.BIT_WIDTH(2), .N_INPUTS(4)) u_if2 ();

  fuzzy_input_serializer #(.BIT_WIDTH(8), .N_INPUTS(8)) u_dut (
    .clock (clk),
    .reset (reset),
    .bus   (u_if)
  );

  fuzzy_input_serializer #(.BIT_WIDTH(2), .N_INPUTS(4)) u_dut2 (
    .clock (clk),
    .reset (reset),
    .bus   (u_if2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model: the latched frame plus the digit index being shown (-1 when idle).
  int          m_pos  = -1;
  logic [63:0] m_d1   = '0;
  logic [63:0] m_d2   = '0;
  int          m2_pos = -1;
  logic [63:0] m2_d1  = '0;
  logic [63:0] m2_d2  = '0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_bits(input logic [63:0] d, input int bw, input int n, input int pos);
    logic [7:0] r;
    r = '0;
    if (pos >= 0)
      for (int k = 0; k < n; k++) r[k] = d[k*bw + bw - 1 - pos];
    return r;
  endfunction

  function automatic logic exp_ready(input int pos, input int bw);
    return (pos < 0) || (pos == bw - 1);
  endfunction

  task automatic model_step(inout int pos, inout logic [63:0] a, inout logic [63:0] b,
                            input logic rst, input logic v,
                            input logic [63:0] d1, input logic [63:0] d2, input int bw);
    logic rdy;
    rdy = exp_ready(pos, bw);
    if (rst) begin
      pos = -1; a = '0; b = '0;
    end else if (v && rdy) begin
      pos = 0; a = d1; b = d2;
    end else if (pos == bw - 1) begin
      pos = -1;
    end else if (pos >= 0) begin
      pos++;
    end
  endtask

  task automatic check_outputs();
    check("start",  64'(u_if.io_start),     64'(m_pos >= 0));
    check("busy",   64'(u_if.io_busy),      64'(m_pos >= 0));
    check("done",   64'(u_if.io_frameDone), 64'(m_pos == 7));
    check("ready",  64'(u_if.io_inReady),   64'(exp_ready(m_pos, 8)));
    check("bits1",  64'(u_if.io_bits1),     64'(exp_bits(m_d1, 8, 8, m_pos)));
    check("bits2",  64'(u_if.io_bits2),     64'(exp_bits(m_d2, 8, 8, m_pos)));
    check("w2_start", 64'(u_if2.io_start),     64'(m2_pos >= 0));
    check("w2_busy",  64'(u_if2.io_busy),      64'(m2_pos >= 0));
    check("w2_done",  64'(u_if2.io_frameDone), 64'(m2_pos == 1));
    check("w2_ready", 64'(u_if2.io_inReady),   64'(exp_ready(m2_pos, 2)));
    check("w2_bits1", 64'(u_if2.io_bits1),     64'(exp_bits(m2_d1, 2, 4, m2_pos)));
    check("w2_bits2", 64'(u_if2.io_bits2),     64'(exp_bits(m2_d2, 2, 4, m2_pos)));
  endtask

  task automatic step(input logic rst, input logic v, input logic [63:0] d1, input logic [63:0] d2);
    logic        v2;
    logic [63:0] e1;
    logic [63:0] e2;
    @(negedge clk);
    check_outputs();
    v2 = ($urandom_range(0, 7) != 0);
    e1 = {56'b0, 8'($urandom)};
    e2 = {56'b0, 8'($urandom)};
    reset           = rst;
    u_if.io_inValid = v;
    u_if.io_inData1 = d1;
    u_if.io_inData2 = d2;
    u_if2.io_inValid = v2;
    u_if2.io_inData1 = e1[7:0];
    u_if2.io_inData2 = e2[7:0];
    @(posedge clk);
    model_step(m_pos, m_d1, m_d2, rst, v, d1, d2, 8);
    model_step(m2_pos, m2_d1, m2_d2, rst, v2, e1, e2, 2);
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, rnd64(), rnd64());
  endtask

  initial begin
    reset = 1'b1;
    u_if.io_inValid  = 1'b0;
    u_if.io_inData1  = '0;
    u_if.io_inData2  = '0;
    u_if2.io_inValid = 1'b0;
    u_if2.io_inData1 = '0;
    u_if2.io_inData2 = '0;
    repeat (2) @(posedge clk);
    step(1'b1, 1'b0, '0, '0);

    // Single frame A5/3C on word 0
    step(1'b0, 1'b1, 64'h00000000000000A5, 64'h000000000000003C);
    idle(10);

    // Back-to-back: valid held through the last digit
    step(1'b0, 1'b1, rnd64(), rnd64());
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 64'h0123456789ABCDEF, 64'hFEDCBA9876543210);
    idle(10);

    // Backpressure with changing data mid-frame
    step(1'b0, 1'b1, rnd64(), rnd64());
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, rnd64(), rnd64());
    idle(4);

    // Mid-frame reset with a transfer offered in the same cycle
    step(1'b0, 1'b1, rnd64(), rnd64());
    idle(3);
    step(1'b1, 1'b1, rnd64(), rnd64());
    idle(10);

    // Word independence: set1 word7 all ones
    step(1'b0, 1'b1, 64'hFF00000000000000, 64'h0);
    idle(10);

    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 49) == 0), 1'($urandom), rnd64(), rnd64());
    idle(10);

    @(negedge clk);
    check_outputs();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
